// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the instruction fetch unit and its helpers.
//   fetch_state_t   : fetch FSM state encoding
//   PC_INCR         : byte increment between sequential instructions
//   BRANCH_OFFSET_W : width of the signed word offset supplied by the core
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    localparam int PC_INCR         = 4;
    localparam int BRANCH_OFFSET_W = 8;

endpackage

// File: rtl/pc_next_calc.sv
// ----------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC generator. Sequential flow advances by one word;
// a taken branch adds a signed word offset relative to PC+4. All arithmetic
// wraps modulo 2^ADDR_WIDTH.
// Ports:
//   PC            in  current instruction byte address
//   BRANCH_EN     in  select branch target instead of PC+4
//   BRANCH_OFFSET in  signed word offset (scaled by 4 here)
//   NEXT_PC       out address of the next instruction to fetch
// ----------------------------------------------------------------------------
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]      PC,
    input  logic                       BRANCH_EN,
    input  logic [BRANCH_OFFSET_W-1:0] BRANCH_OFFSET,
    output logic [ADDR_WIDTH-1:0]      NEXT_PC
);

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic [ADDR_WIDTH-1:0] offset_bytes;

    assign pc_plus4     = PC + ADDR_WIDTH'(PC_INCR);
    assign offset_ext   = {{(ADDR_WIDTH-BRANCH_OFFSET_W){BRANCH_OFFSET[BRANCH_OFFSET_W-1]}},
                           BRANCH_OFFSET};
    assign offset_bytes = offset_ext << 2;

    always_comb begin
        NEXT_PC = pc_plus4;
        if (BRANCH_EN) begin
            NEXT_PC = pc_plus4 + offset_bytes;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, reads instruction words from instruction memory over a
// READ/BUSYWAIT handshake and presents them to the core with a valid flag.
// The core consumes a word by leaving STALL low while INSTR_VALID is high;
// on that edge it may redirect the next fetch with a PC-relative branch.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | just out of reset, no request; moves to S_FETCH on next edge
//   S_FETCH | IMEM_READ high at PC; capture word on edge with BUSYWAIT low
//   S_ISSUE | word valid to core; hold while STALL, advance PC on consume
//
// Ports:
//   CLK, RESET              clock (rising edge), async active-low reset
//   PC, INSTRUCTION         current instruction address and word
//   INSTR_VALID             INSTRUCTION holds the word at PC
//   STALL                   core cannot consume this cycle
//   BRANCH_EN/BRANCH_OFFSET branch request, sampled on the consume edge only
//   IMEM_READ/IMEM_ADDRESS  memory request
//   IMEM_READDATA           memory read data
//   IMEM_BUSYWAIT           memory not ready
//   INSTR_COUNT             instructions consumed (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    output logic [ADDR_WIDTH-1:0]      PC,
    output logic [INSTR_WIDTH-1:0]     INSTRUCTION,
    output logic                       INSTR_VALID,
    input  logic                       STALL,
    input  logic                       BRANCH_EN,
    input  logic [BRANCH_OFFSET_W-1:0] BRANCH_OFFSET,
    output logic                       IMEM_READ,
    output logic [ADDR_WIDTH-1:0]      IMEM_ADDRESS,
    input  logic [INSTR_WIDTH-1:0]     IMEM_READDATA,
    input  logic                       IMEM_BUSYWAIT,
    output logic [31:0]                INSTR_COUNT
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [31:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0]  next_pc;

    pc_next_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_next_calc (
        .PC            (pc_q),
        .BRANCH_EN     (BRANCH_EN),
        .BRANCH_OFFSET (BRANCH_OFFSET),
        .NEXT_PC       (next_pc)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        count_d   = count_q;
        IMEM_READ = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    instr_d = IMEM_READDATA;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!STALL) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The address bus always reflects PC; it is only meaningful while
    // IMEM_READ is high, and PC is word-aligned by construction.
    assign IMEM_ADDRESS = pc_q;
    assign PC           = pc_q;
    assign INSTRUCTION  = instr_q;
    assign INSTR_VALID  = valid_q;
    assign INSTR_COUNT  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk_sys;
    logic        rst_b;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic        branch_en;
    logic [7:0]  branch_offset;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;
    logic [31:0] instr_count;

    logic        rst_w_b;
    logic [31:0] pc_w;
    logic [31:0] instruction_w;
    logic        instr_valid_w;
    logic        imem_read_w;
    logic [31:0] imem_address_w;
    logic [31:0] imem_readdata_w;
    logic [31:0] instr_count_w;

    int n_chk;
    int n_pass;

    instr_fetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .CLK           (clk_sys),
        .RESET         (rst_b),
        .PC            (pc),
        .INSTRUCTION   (instruction),
        .INSTR_VALID   (instr_valid),
        .STALL         (stall),
        .BRANCH_EN     (branch_en),
        .BRANCH_OFFSET (branch_offset),
        .IMEM_READ     (imem_read),
        .IMEM_ADDRESS  (imem_address),
        .IMEM_READDATA (imem_readdata),
        .IMEM_BUSYWAIT (imem_busywait),
        .INSTR_COUNT   (instr_count)
    );

    instr_fetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'hFFFF_FFF8)
    ) dut_wrap (
        .CLK           (clk_sys),
        .RESET         (rst_w_b),
        .PC            (pc_w),
        .INSTRUCTION   (instruction_w),
        .INSTR_VALID   (instr_valid_w),
        .STALL         (1'b0),
        .BRANCH_EN     (1'b0),
        .BRANCH_OFFSET (8'h00),
        .IMEM_READ     (imem_read_w),
        .IMEM_ADDRESS  (imem_address_w),
        .IMEM_READDATA (imem_readdata_w),
        .IMEM_BUSYWAIT (1'b0),
        .INSTR_COUNT   (instr_count_w)
    );

    // memory model: word[i] = A000_0000 + i
    assign imem_readdata   = 32'hA000_0000 + (imem_address >> 2);
    assign imem_readdata_w = 32'hA000_0000 + (imem_address_w >> 2);

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h want %08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_b         = 1'b0;
        rst_w_b       = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_offset = 8'h00;
        imem_busywait = 1'b0;

        tick();
        tick();
        chk("rst_pc",    pc,          32'h0);
        chk("rst_valid", instr_valid, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_read",  imem_read,   32'h0);
        chk("rst_instr", instruction, 32'h0);

        rst_b = 1'b1;
        tick();
        chk("e1_read",  imem_read,    32'h1);
        chk("e1_addr",  imem_address, 32'h0);
        chk("e1_valid", instr_valid,  32'h0);
        tick();
        chk("e2_valid", instr_valid,  32'h1);
        chk("e2_pc",    pc,           32'h0);
        chk("e2_instr", instruction,  32'hA000_0000);
        chk("e2_read",  imem_read,    32'h0);

        tick();
        chk("c1_pc",    pc,          32'h4);
        chk("c1_valid", instr_valid, 32'h0);
        chk("c1_count", instr_count, 32'h1);
        tick();
        chk("f4_instr", instruction, 32'hA000_0001);

        // stall at PC=4
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl_pc",    pc,          32'h4);
            chk("stl_instr", instruction, 32'hA000_0001);
            chk("stl_valid", instr_valid, 32'h1);
            chk("stl_read",  imem_read,   32'h0);
            chk("stl_count", instr_count, 32'h1);
        end
        stall = 1'b0;
        tick();
        chk("pst_pc",    imem_address, 32'h8);
        chk("pst_read",  imem_read,    32'h1);
        chk("pst_count", instr_count,  32'h2);

        // wait states at PC=8, with a branch request that must be ignored
        imem_busywait = 1'b1;
        branch_en     = 1'b1;
        branch_offset = 8'hFB;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_read",  imem_read,    32'h1);
            chk("ws_addr",  imem_address, 32'h8);
            chk("ws_valid", instr_valid,  32'h0);
        end
        imem_busywait = 1'b0;
        tick();
        chk("ws_instr", instruction, 32'hA000_0002);
        chk("ws_pc",    pc,          32'h8);
        chk("ws_vld",   instr_valid, 32'h1);
        branch_en = 1'b0;

        tick();
        chk("c3_pc", pc, 32'hC);
        tick();
        chk("f_c_instr", instruction, 32'hA000_0003);
        tick();
        chk("c4_pc",    pc,          32'h10);
        chk("c4_count", instr_count, 32'h4);
        tick();
        chk("f10_instr", instruction, 32'hA000_0004);

        // branch +3 words from 0x10 -> 0x20; keep BRANCH_EN high through fetch
        branch_en     = 1'b1;
        branch_offset = 8'h03;
        tick();
        chk("br_fwd", pc, 32'h20);
        tick();
        chk("br_fetch_pc", pc,          32'h20);
        chk("br_instr",    instruction, 32'hA000_0008);
        branch_offset = 8'hFB;
        tick();
        chk("br_back", pc, 32'h10);
        tick();
        chk("br_b_instr", instruction, 32'hA000_0004);
        branch_offset = 8'hF8;
        tick();
        chk("br_neg_wrap", pc, 32'hFFFF_FFF4);
        branch_en = 1'b0;
        tick();
        chk("nw_instr", instruction, 32'hA000_0000 + (32'hFFFF_FFF4 >> 2));

        // async reset while waiting in S_FETCH
        tick();
        chk("pre_read", imem_read, 32'h1);
        imem_busywait = 1'b1;
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("ar_read",  imem_read,   32'h0);
        chk("ar_valid", instr_valid, 32'h0);
        chk("ar_pc",    pc,          32'h0);
        chk("ar_count", instr_count, 32'h0);
        @(negedge clk_sys);
        rst_b         = 1'b1;
        imem_busywait = 1'b0;
        tick();
        tick();
        chk("ar_rst_pc",    pc,          32'h0);
        chk("ar_rst_instr", instruction, 32'hA000_0000);

        // wrap-around instance
        rst_w_b = 1'b1;
        tick();
        tick();
        chk("wr_pc0",  pc_w,          32'hFFFF_FFF8);
        chk("wr_vld0", instr_valid_w, 32'h1);
        tick();
        tick();
        chk("wr_pc1", pc_w, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("wr_pc2",    pc_w,          32'h0000_0000);
        chk("wr_instr2", instruction_w, 32'hA000_0000);
        tick();
        chk("wr_count", instr_count_w, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
